// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR file.
//   - CSR address constants, ECALL cause code, mstatus bit positions, misa value
//   - csr_how / write-source encodings
//   - csr_state_t snapshot of all architectural CSR state
//   - csr_lookup(): address decode returning read value and mapped/writable flags
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam int          MSTATUS_MIE_BIT  = 3;
  localparam int          MSTATUS_MPIE_BIT = 7;
  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;

  typedef enum logic [1:0] {
    CSR_WRITE = 2'b00,
    CSR_SET   = 2'b01,
    CSR_CLEAR = 2'b10,
    CSR_NONE  = 2'b11
  } csr_how_e;

  typedef enum logic [1:0] {
    WSRC_RS1   = 2'b00,
    WSRC_TRAP  = 2'b01,
    WSRC_RSVD2 = 2'b10,
    WSRC_RSVD3 = 2'b11
  } csr_wsrc_e;

  typedef struct packed {
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [63:0] mcycle;
    logic [63:0] minstret;
  } csr_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        mapped;
    logic        writable;
  } csr_lookup_t;

  // MPP is hardwired to machine mode; only MIE/MPIE are stored.
  function automatic logic [31:0] mstatus_value(input logic mie, input logic mpie);
    logic [31:0] v;
    v = 32'h0000_1800;
    v[MSTATUS_MIE_BIT]  = mie;
    v[MSTATUS_MPIE_BIT] = mpie;
    return v;
  endfunction

  function automatic csr_lookup_t csr_lookup(input logic [11:0] addr, input csr_state_t st);
    csr_lookup_t r;
    r.data     = 32'h0;
    r.mapped   = 1'b1;
    r.writable = 1'b1;
    case (addr)
      CSR_MSTATUS:   r.data = mstatus_value(st.mstatus_mie, st.mstatus_mpie);
      CSR_MIE:       r.data = st.mie;
      CSR_MTVEC:     r.data = st.mtvec;
      CSR_MSCRATCH:  r.data = st.mscratch;
      CSR_MEPC:      r.data = st.mepc;
      CSR_MCAUSE:    r.data = st.mcause;
      CSR_MTVAL:     r.data = st.mtval;
      CSR_MCYCLE:    r.data = st.mcycle[31:0];
      CSR_MCYCLEH:   r.data = st.mcycle[63:32];
      CSR_MINSTRET:  r.data = st.minstret[31:0];
      CSR_MINSTRETH: r.data = st.minstret[63:32];
      CSR_MISA:      begin r.data = MISA_VALUE;         r.writable = 1'b0; end
      CSR_MIP:       begin r.data = 32'h0;              r.writable = 1'b0; end
      CSR_MHARTID:   begin r.data = 32'h0;              r.writable = 1'b0; end
      CSR_CYCLE:     begin r.data = st.mcycle[31:0];    r.writable = 1'b0; end
      CSR_CYCLEH:    begin r.data = st.mcycle[63:32];   r.writable = 1'b0; end
      CSR_INSTRET:   begin r.data = st.minstret[31:0];  r.writable = 1'b0; end
      CSR_INSTRETH:  begin r.data = st.minstret[63:32]; r.writable = 1'b0; end
      default:       begin r.mapped = 1'b0;             r.writable = 1'b0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/csr_if.sv
// csr_if: decoder <-> CSR file connection.
//   master (decoder side): drives read/write indices, write controls, mret,
//     rs1_data, pc, instr_retire; receives csr_read_data, mtvec_q, mepc_q,
//     mie_global, illegal_csr.
//   slave (csr_file): the reverse.
interface csr_if;
  import csr_pkg::*;

  logic [11:0] csr_read_index;
  logic        csr_write;
  logic [11:0] csr_write_index;
  logic [1:0]  csr_writesource;
  logic [1:0]  csr_how;
  logic        mret;
  logic [31:0] rs1_data;
  logic [31:0] pc;
  logic        instr_retire;
  logic [31:0] csr_read_data;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic        mie_global;
  logic        illegal_csr;

  modport master (
    output csr_read_index, csr_write, csr_write_index, csr_writesource, csr_how,
           mret, rs1_data, pc, instr_retire,
    input  csr_read_data, mtvec_q, mepc_q, mie_global, illegal_csr
  );

  modport slave (
    input  csr_read_index, csr_write, csr_write_index, csr_writesource, csr_how,
           mret, rs1_data, pc, instr_retire,
    output csr_read_data, mtvec_q, mepc_q, mie_global, illegal_csr
  );
endinterface

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter with increment enable and per-half write ports.
//   clk, rst_n (sync, active-low), inc (count enable), wr_lo / wr_hi (replace
//   the low / high half with wdata), value (current count).
// A write to either half freezes the other half and suppresses the increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  // Counter state: reset, half-word replace, or carry-propagating increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= 64'h0;
    end else if (wr_lo) begin
      value[31:0] <= wdata;
    end else if (wr_hi) begin
      value[63:32] <= wdata;
    end else if (inc) begin
      value <= value + 64'd1;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file for the RV32I core.
//   clk, rst_n (sync, active-low) plus csr_if.slave bus carrying the decoder
//   controls (read/write index, write enable/source/how, mret, rs1_data, pc,
//   instr_retire) and results (csr_read_data, mtvec_q, mepc_q, mie_global,
//   illegal_csr).
// csr_read_data doubles as the PC-mux redirect: mtvec during ECALL, mepc during
// MRET, otherwise the register at csr_read_index.
module csr_file
  import csr_pkg::*;
(
  input logic   clk,
  input logic   rst_n,
  csr_if.slave  bus
);

  logic        mstatus_mie_r;
  logic        mstatus_mpie_r;
  logic [31:0] mie_r;
  logic [31:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [31:0] mtval_r;
  logic [63:0] mcycle_s;
  logic [63:0] minstret_s;

  csr_state_t  state_s;
  csr_lookup_t rd_lookup_s;
  csr_lookup_t wr_lookup_s;
  logic        rd_flags_unused_s;
  logic        trap_s;
  logic        sw_attempt_s;
  logic        illegal_s;
  logic        sw_we_s;
  logic [31:0] wdata_s;
  logic [31:0] rd_data_s;

  // Snapshot of all CSR state for the address decoder.
  always_comb begin
    state_s.mstatus_mie  = mstatus_mie_r;
    state_s.mstatus_mpie = mstatus_mpie_r;
    state_s.mie          = mie_r;
    state_s.mtvec        = mtvec_r;
    state_s.mscratch     = mscratch_r;
    state_s.mepc         = mepc_r;
    state_s.mcause       = mcause_r;
    state_s.mtval        = mtval_r;
    state_s.mcycle       = mcycle_s;
    state_s.minstret     = minstret_s;
  end

  // Write decode: trap detection, legality, and read-modify-write data.
  always_comb begin
    trap_s = bus.csr_write && (bus.csr_writesource == WSRC_TRAP);
    // Set/clear with a zero mask is architecturally a pure read.
    sw_attempt_s = bus.csr_write && (bus.csr_writesource == WSRC_RS1) &&
                   (bus.csr_how != CSR_NONE) &&
                   !((bus.csr_how != CSR_WRITE) && (bus.rs1_data == 32'h0));
    wr_lookup_s = csr_lookup(bus.csr_write_index, state_s);
    illegal_s   = sw_attempt_s && !(wr_lookup_s.mapped && wr_lookup_s.writable);
    // Trap and software write have different sources, so only MRET can pre-empt.
    sw_we_s     = sw_attempt_s && !illegal_s && !bus.mret;
    case (bus.csr_how)
      CSR_SET:   wdata_s = wr_lookup_s.data | bus.rs1_data;
      CSR_CLEAR: wdata_s = wr_lookup_s.data & ~bus.rs1_data;
      default:   wdata_s = bus.rs1_data;
    endcase
  end

  // Read path and redirect-target override.
  always_comb begin
    rd_lookup_s       = csr_lookup(bus.csr_read_index, state_s);
    rd_flags_unused_s = rd_lookup_s.mapped ^ rd_lookup_s.writable;
    if (trap_s) begin
      rd_data_s = mtvec_r;
    end else if (bus.mret) begin
      rd_data_s = mepc_r;
    end else begin
      rd_data_s = rd_lookup_s.data;
    end
  end

  // Trap state and software-writable registers; trap > MRET > software write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      mie_r          <= 32'h0;
      mtvec_r        <= 32'h0;
      mscratch_r     <= 32'h0;
      mepc_r         <= 32'h0;
      mcause_r       <= 32'h0;
      mtval_r        <= 32'h0;
    end else if (trap_s) begin
      mepc_r         <= bus.pc & 32'hFFFF_FFFC;
      mcause_r       <= CAUSE_ECALL_M;
      mtval_r        <= 32'h0;
      mstatus_mpie_r <= mstatus_mie_r;
      mstatus_mie_r  <= 1'b0;
    end else if (bus.mret) begin
      mstatus_mie_r  <= mstatus_mpie_r;
      mstatus_mpie_r <= 1'b1;
    end else if (sw_we_s) begin
      case (bus.csr_write_index)
        CSR_MSTATUS: begin
          mstatus_mie_r  <= wdata_s[MSTATUS_MIE_BIT];
          mstatus_mpie_r <= wdata_s[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_r      <= wdata_s;
        CSR_MTVEC:    mtvec_r    <= wdata_s & 32'hFFFF_FFFC;
        CSR_MSCRATCH: mscratch_r <= wdata_s;
        CSR_MEPC:     mepc_r     <= wdata_s & 32'hFFFF_FFFC;
        CSR_MCAUSE:   mcause_r   <= wdata_s;
        CSR_MTVAL:    mtval_r    <= wdata_s;
        default:      mtval_r    <= mtval_r;  // counter halves live in csr_counter64
      endcase
    end else begin
      mtval_r <= mtval_r;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (sw_we_s && (bus.csr_write_index == CSR_MCYCLE)),
    .wr_hi (sw_we_s && (bus.csr_write_index == CSR_MCYCLEH)),
    .wdata (wdata_s),
    .value (mcycle_s)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.instr_retire),
    .wr_lo (sw_we_s && (bus.csr_write_index == CSR_MINSTRET)),
    .wr_hi (sw_we_s && (bus.csr_write_index == CSR_MINSTRETH)),
    .wdata (wdata_s),
    .value (minstret_s)
  );

  assign bus.csr_read_data = rd_data_s;
  assign bus.mtvec_q       = mtvec_r;
  assign bus.mepc_q        = mepc_r;
  assign bus.mie_global    = mstatus_mie_r;
  assign bus.illegal_csr   = illegal_s;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus a randomized run,
// all compared against a behavioural model of the CSR architecture.
module tb_csr_file;
  import csr_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csr_if bus();
  csr_file dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Behavioural model: plain read/write registers by address, mstatus flags, counters.
  logic [31:0] m_rw [int];
  bit          m_mie, m_mpie;
  logic [63:0] m_cyc, m_ins;

  logic [11:0] addr_tab [0:17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                   12'hB82, 12'hC00, 12'hC80, 12'hF14, 12'h7C0, 12'h000};

  function automatic void model_reset();
    m_rw[32'h304] = 32'h0; m_rw[32'h305] = 32'h0; m_rw[32'h340] = 32'h0;
    m_rw[32'h341] = 32'h0; m_rw[32'h342] = 32'h0; m_rw[32'h343] = 32'h0;
    m_mie = 1'b0; m_mpie = 1'b0; m_cyc = 64'h0; m_ins = 64'h0;
  endfunction

  // Returns 1 when mapped; w reports software-writability.
  function automatic bit m_read(input int a, output logic [31:0] v, output bit w);
    v = 32'h0;
    w = 1'b1;
    if (m_rw.exists(a)) begin
      v = m_rw[a];
      return 1'b1;
    end
    case (a)
      32'h300: v = 32'h0000_1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      32'hB00: v = m_cyc[31:0];
      32'hB80: v = m_cyc[63:32];
      32'hB02: v = m_ins[31:0];
      32'hB82: v = m_ins[63:32];
      32'h301: begin w = 1'b0; v = 32'h4000_0100; end
      32'h344, 32'hF14: w = 1'b0;
      32'hC00: begin w = 1'b0; v = m_cyc[31:0]; end
      32'hC80: begin w = 1'b0; v = m_cyc[63:32]; end
      32'hC02: begin w = 1'b0; v = m_ins[31:0]; end
      32'hC82: begin w = 1'b0; v = m_ins[63:32]; end
      default: begin w = 1'b0; return 1'b0; end
    endcase
    return 1'b1;
  endfunction

  function automatic bit is_trap();
    return bus.csr_write && (bus.csr_writesource == 2'b01);
  endfunction

  function automatic bit sw_attempt();
    return bus.csr_write && (bus.csr_writesource == 2'b00) && (bus.csr_how != 2'b11) &&
           !((bus.csr_how != 2'b00) && (bus.rs1_data == 32'h0));
  endfunction

  function automatic bit exp_illegal();
    logic [31:0] v; bit w, ok;
    ok = m_read(int'(bus.csr_write_index), v, w);
    return sw_attempt() && !(ok && w);
  endfunction

  function automatic logic [31:0] exp_rd();
    logic [31:0] v; bit w, ok;
    if (is_trap()) return m_rw[32'h305];
    if (bus.mret)  return m_rw[32'h341];
    ok = m_read(int'(bus.csr_read_index), v, w);
    return ok ? v : 32'h0;
  endfunction

  // Architectural effect of one rising edge with the current inputs.
  function automatic void model_edge();
    logic [31:0] old_v, new_v; bit ok, wr; int a;
    logic [63:0] cyc_n, ins_n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cyc_n = m_cyc + 64'd1;
    ins_n = m_ins + {63'd0, bus.instr_retire};
    a  = int'(bus.csr_write_index);
    ok = m_read(a, old_v, wr);
    if (is_trap()) begin
      m_rw[32'h341] = {bus.pc[31:2], 2'b00};
      m_rw[32'h342] = 32'd11;
      m_rw[32'h343] = 32'h0;
      m_mpie = m_mie;
      m_mie  = 1'b0;
    end else if (bus.mret) begin
      m_mie  = m_mpie;
      m_mpie = 1'b1;
    end else if (sw_attempt() && ok && wr) begin
      case (bus.csr_how)
        2'b01:   new_v = old_v | bus.rs1_data;
        2'b10:   new_v = old_v & ~bus.rs1_data;
        default: new_v = bus.rs1_data;
      endcase
      if (a == 32'h305 || a == 32'h341) new_v[1:0] = 2'b00;
      if (m_rw.exists(a)) m_rw[a] = new_v;
      else begin
        case (a)
          32'h300: begin m_mie = new_v[3]; m_mpie = new_v[7]; end
          32'hB00: cyc_n = {m_cyc[63:32], new_v};
          32'hB80: cyc_n = {new_v, m_cyc[31:0]};
          32'hB02: ins_n = {m_ins[63:32], new_v};
          32'hB82: ins_n = {new_v, m_ins[31:0]};
          default: ;
        endcase
      end
    end
    m_cyc = cyc_n;
    m_ins = ins_n;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [1:0] src, input logic [1:0] how,
                       input logic [11:0] widx, input logic [31:0] d,
                       input logic [11:0] ridx, input logic mr, input logic [31:0] p);
    bus.csr_write       = w;
    bus.csr_writesource = src;
    bus.csr_how         = how;
    bus.csr_write_index = widx;
    bus.rs1_data        = d;
    bus.csr_read_index  = ridx;
    bus.mret            = mr;
    bus.pc              = p;
    bus.instr_retire    = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input logic [11:0] ridx);
    drive(1'b0, 2'b00, 2'b11, 12'h000, 32'h0, ridx, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(12'h300);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (bus.csr_read_data !== 32'h0000_1800) begin bad++; $display("FAIL reset_mstatus got=%h want=%h", bus.csr_read_data, 32'h0000_1800); end
    bus.csr_read_index = 12'h301; #1;
    total++; if (bus.csr_read_data !== 32'h4000_0100) begin bad++; $display("FAIL reset_misa got=%h want=%h", bus.csr_read_data, 32'h4000_0100); end
    bus.csr_read_index = 12'hF14; #1;
    total++; if (bus.csr_read_data !== 32'h0) begin bad++; $display("FAIL reset_mhartid got=%h want=0", bus.csr_read_data); end
    total++; if (bus.mtvec_q !== 32'h0 || bus.mepc_q !== 32'h0 || bus.mie_global !== 1'b0 || bus.illegal_csr !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got mtvec=%h mepc=%h mie=%b ill=%b want all 0", bus.mtvec_q, bus.mepc_q, bus.mie_global, bus.illegal_csr); end
    tick();
  endtask

  task automatic test_rw_basic();
    drive(1'b1, 2'b00, 2'b00, 12'h305, 32'h0000_0103, 12'h305, 1'b0, 32'h0); #1;
    total++; if (bus.csr_read_data !== 32'h0) begin bad++; $display("FAIL mtvec_same_cycle_old got=%h want=0", bus.csr_read_data); end
    tick();
    idle(12'h305); #1;
    total++; if (bus.mtvec_q !== 32'h100 || bus.csr_read_data !== 32'h100) begin bad++; $display("FAIL mtvec_write got q=%h rd=%h want=100", bus.mtvec_q, bus.csr_read_data); end
    drive(1'b1, 2'b00, 2'b01, 12'h304, 32'h8, 12'h304, 1'b0, 32'h0);
    tick();
    idle(12'h304); #1;
    total++; if (bus.csr_read_data !== 32'h8) begin bad++; $display("FAIL mie_set got=%h want=8", bus.csr_read_data); end
    drive(1'b1, 2'b00, 2'b10, 12'h304, 32'h8, 12'h304, 1'b0, 32'h0); #1;
    total++; if (bus.csr_read_data !== 32'h8) begin bad++; $display("FAIL mie_clear_same_cycle got=%h want=8", bus.csr_read_data); end
    tick();
    idle(12'h304); #1;
    total++; if (bus.csr_read_data !== 32'h0) begin bad++; $display("FAIL mie_clear got=%h want=0", bus.csr_read_data); end
  endtask

  task automatic test_trap_mret();
    drive(1'b1, 2'b00, 2'b01, 12'h300, 32'h8, 12'h300, 1'b0, 32'h0);
    tick();
    idle(12'h300); #1;
    total++; if (bus.mie_global !== 1'b1 || bus.csr_read_data !== 32'h1808) begin bad++; $display("FAIL mstatus_set_mie got mie=%b rd=%h want 1/1808", bus.mie_global, bus.csr_read_data); end
    drive(1'b1, 2'b01, 2'b00, 12'h340, 32'hDEAD_BEEF, 12'h305, 1'b0, 32'h0000_0046); #1;
    total++; if (bus.csr_read_data !== 32'h100 || bus.illegal_csr !== 1'b0) begin bad++; $display("FAIL ecall_redirect got rd=%h ill=%b want 100/0", bus.csr_read_data, bus.illegal_csr); end
    tick();
    idle(12'h342); #1;
    total++; if (bus.csr_read_data !== 32'd11 || bus.mepc_q !== 32'h44 || bus.mie_global !== 1'b0) begin
      bad++; $display("FAIL ecall_state got mcause=%h mepc=%h mie=%b want b/44/0", bus.csr_read_data, bus.mepc_q, bus.mie_global); end
    bus.csr_read_index = 12'h300; #1;
    total++; if (bus.csr_read_data !== 32'h1880) begin bad++; $display("FAIL ecall_mstatus got=%h want=1880", bus.csr_read_data); end
    bus.csr_read_index = 12'h340; #1;
    total++; if (bus.csr_read_data !== 32'h0) begin bad++; $display("FAIL ecall_mscratch_untouched got=%h want=0", bus.csr_read_data); end
    drive(1'b0, 2'b00, 2'b11, 12'h000, 32'h0, 12'h341, 1'b1, 32'h0); #1;
    total++; if (bus.csr_read_data !== 32'h44) begin bad++; $display("FAIL mret_target got=%h want=44", bus.csr_read_data); end
    tick();
    idle(12'h300); #1;
    total++; if (bus.mie_global !== 1'b1 || bus.mepc_q !== 32'h44 || bus.csr_read_data !== 32'h1888) begin
      bad++; $display("FAIL mret_state got mie=%b mepc=%h mstatus=%h want 1/44/1888", bus.mie_global, bus.mepc_q, bus.csr_read_data); end
  endtask

  task automatic test_counter_wrap();
    drive(1'b1, 2'b00, 2'b00, 12'hB00, 32'hFFFF_FFFE, 12'hB00, 1'b0, 32'h0);
    tick();
    drive(1'b1, 2'b00, 2'b00, 12'hB80, 32'h0, 12'hB00, 1'b0, 32'h0); #1;
    total++; if (bus.csr_read_data !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mcycle_lo_write got=%h want=fffffffe", bus.csr_read_data); end
    tick();
    idle(12'hB00); #1;
    total++; if (bus.csr_read_data !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mcycle_hold_on_write got=%h want=fffffffe", bus.csr_read_data); end
    tick();
    #1;
    total++; if (bus.csr_read_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mcycle_inc got=%h want=ffffffff", bus.csr_read_data); end
    bus.csr_read_index = 12'hB80; #1;
    total++; if (bus.csr_read_data !== 32'h0) begin bad++; $display("FAIL mcycleh_before_carry got=%h want=0", bus.csr_read_data); end
    tick();
    bus.csr_read_index = 12'hB00; #1;
    total++; if (bus.csr_read_data !== 32'h0) begin bad++; $display("FAIL mcycle_wrap got=%h want=0", bus.csr_read_data); end
    bus.csr_read_index = 12'hB80; #1;
    total++; if (bus.csr_read_data !== 32'h1) begin bad++; $display("FAIL mcycleh_carry got=%h want=1", bus.csr_read_data); end
    bus.csr_read_index = 12'hC80; #1;
    total++; if (bus.csr_read_data !== 32'h1) begin bad++; $display("FAIL cycleh_shadow got=%h want=1", bus.csr_read_data); end
  endtask

  task automatic test_illegal();
    logic [31:0] c0;
    drive(1'b1, 2'b00, 2'b00, 12'hF14, 32'h5, 12'hF14, 1'b0, 32'h0); #1;
    total++; if (bus.illegal_csr !== 1'b1) begin bad++; $display("FAIL illegal_mhartid got=%b want=1", bus.illegal_csr); end
    tick();
    idle(12'hF14); #1;
    total++; if (bus.csr_read_data !== 32'h0) begin bad++; $display("FAIL mhartid_kept got=%h want=0", bus.csr_read_data); end
    drive(1'b1, 2'b00, 2'b00, 12'h7C0, 32'h5, 12'h7C0, 1'b0, 32'h0); #1;
    total++; if (bus.illegal_csr !== 1'b1 || bus.csr_read_data !== 32'h0) begin bad++; $display("FAIL illegal_unmapped got ill=%b rd=%h want 1/0", bus.illegal_csr, bus.csr_read_data); end
    tick();
    drive(1'b1, 2'b00, 2'b01, 12'h340, 32'h0, 12'hB00, 1'b0, 32'h0); #1;
    c0 = m_cyc[31:0];
    total++; if (bus.illegal_csr !== 1'b0 || bus.csr_read_data !== c0) begin bad++; $display("FAIL set_zero_no_write got ill=%b cyc=%h want 0/%h", bus.illegal_csr, bus.csr_read_data, c0); end
    tick();
    idle(12'hB00); #1;
    total++; if (bus.csr_read_data !== c0 + 32'd1) begin bad++; $display("FAIL mcycle_runs got=%h want=%h", bus.csr_read_data, c0 + 32'd1); end
  endtask

  task automatic test_reset_during_trap();
    drive(1'b1, 2'b00, 2'b00, 12'h340, 32'h1234_5678, 12'h340, 1'b0, 32'h0);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 2'b01, 2'b00, 12'h000, 32'h0, 12'h305, 1'b0, 32'h0000_1234);
    tick();
    rst_n = 1'b1;
    idle(12'h341); #1;
    total++; if (bus.mepc_q !== 32'h0 || bus.csr_read_data !== 32'h0 || bus.mtvec_q !== 32'h0) begin
      bad++; $display("FAIL rst_over_trap got mepc=%h rd=%h mtvec=%h want 0", bus.mepc_q, bus.csr_read_data, bus.mtvec_q); end
    bus.csr_read_index = 12'h300; #1;
    total++; if (bus.csr_read_data !== 32'h1800) begin bad++; $display("FAIL rst_over_trap_mstatus got=%h want=1800", bus.csr_read_data); end
    bus.csr_read_index = 12'h340; #1;
    total++; if (bus.csr_read_data !== 32'h0) begin bad++; $display("FAIL rst_mscratch got=%h want=0", bus.csr_read_data); end
    bus.csr_read_index = 12'hB00; #1;
    total++; if (bus.csr_read_data !== 32'h0) begin bad++; $display("FAIL rst_mcycle got=%h want=0", bus.csr_read_data); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      bus.csr_write       = 1'($urandom_range(0, 1));
      bus.csr_writesource = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.csr_how         = 2'($urandom_range(0, 3));
      bus.csr_write_index = addr_tab[$urandom_range(0, 17)];
      bus.rs1_data        = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      bus.csr_read_index  = addr_tab[$urandom_range(0, 17)];
      bus.mret            = ($urandom_range(0, 7) == 0);
      bus.pc              = $urandom;
      bus.instr_retire    = 1'($urandom_range(0, 1));
      #1;
      e = exp_rd();
      total++; if (bus.csr_read_data !== e) begin bad++; $display("FAIL rnd_read i=%0d idx=%h got=%h want=%h", i, bus.csr_read_index, bus.csr_read_data, e); end
      total++; if (bus.illegal_csr !== exp_illegal()) begin bad++; $display("FAIL rnd_illegal i=%0d got=%b want=%b", i, bus.illegal_csr, exp_illegal()); end
      total++; if (bus.mtvec_q !== m_rw[32'h305]) begin bad++; $display("FAIL rnd_mtvec i=%0d got=%h want=%h", i, bus.mtvec_q, m_rw[32'h305]); end
      total++; if (bus.mepc_q !== m_rw[32'h341]) begin bad++; $display("FAIL rnd_mepc i=%0d got=%h want=%h", i, bus.mepc_q, m_rw[32'h341]); end
      total++; if (bus.mie_global !== m_mie) begin bad++; $display("FAIL rnd_mie i=%0d got=%b want=%b", i, bus.mie_global, m_mie); end
      tick();
    end
    rst_n = 1'b1;
    idle(12'h300);
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rw_basic();
    test_trap_mret();
    test_counter_wrap();
    test_illegal();
    test_reset_during_trap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_file.md
# csr_file

- Machine-mode control-and-status register file for the RV32I core.
- Sits directly downstream of the instruction decoder. It consumes the decoder's CSR read index, write index, write enable, write-source and write-mode controls.
- Returns the CSR read value to the writeback mux and to the PC mux; ECALL redirects to mtvec, MRET returns to mepc.
- Holds trap state (mstatus, mepc, mcause, mtval) and free-running 64-bit cycle and retired-instruction counters.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- csr_read_index  in  12  CSR address read combinationally.
- csr_write  in  1  write enable for this cycle's instruction.
- csr_write_index  in  12  CSR address to update.
- csr_writesource  in  2  00 = rs1_data (CSRRW/S/C); 01 = trap entry (ECALL); 10/11 reserved, treated as no write.
- csr_how  in  2  00 write, 01 set, 10 clear, 11 no write.
- mret  in  1  MRET executing this cycle.
- rs1_data  in  32  operand for CSRRW/S/C.
- pc  in  32  PC of the current instruction.
- instr_retire  in  1  one instruction retires this cycle.
- csr_read_data  out  32  value at csr_read_index; 0 if unmapped.
- mtvec_q  out  32  current mtvec.
- mepc_q  out  32  current mepc.
- mie_global  out  1  mstatus.MIE.
- illegal_csr  out  1  csr_write (source 00) targets an unmapped or read-only address.

## Operation
- Mapped registers, read/write:
  - mstatus 0x300: MIE bit 3, MPIE bit 7; MPP[12:11] reads 2'b11 and is read-only; all other bits read 0.
  - mie 0x304.
  - mtvec 0x305: bits [1:0] forced to 00, direct mode only.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] forced to 00.
  - mcause 0x342.
  - mtval 0x343.
  - mcycle 0xB00 / mcycleh 0xB80.
  - minstret 0xB02 / minstreth 0xB82.
- Mapped registers, read-only:
  - misa 0x301 = 0x4000_0100.
  - mip 0x344 = 0.
  - mhartid 0xF14 = 0.
  - cycle/cycleh 0xC00/0xC80 and instret/instreth 0xC02/0xC82 shadow the counters.
- Write data for source 00 is computed from old = current value and d = rs1_data:
  - write: new = d.
  - set: new = old | d.
  - clear: new = old & ~d.
  - Set or clear with d == 0 is no write: no register update and illegal_csr stays 0.
- Trap entry, when csr_write = 1 and csr_writesource = 01; csr_how and csr_write_index are ignored:
  - mepc ← {pc[31:2], 2'b00}.
  - mcause ← 32'd11.
  - mtval ← 0.
  - MPIE ← MIE, then MIE ← 0.
- MRET: MIE ← MPIE and MPIE ← 1. No other register changes.
- Priority: trap entry > MRET > software write; the lower-priority action is dropped that cycle.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when instr_retire = 1.
  - The 64-bit carry propagates from the low half into the high half (0xFFFF_FFFF rolls over to 0 and the high half increments).
  - A software write to either half replaces that half. The whole 64-bit counter does not increment that cycle; the other half holds.
- Illegal writes (illegal_csr = 1) change no state.

## Timing
- Reset (rst_n = 0 at an edge):
  - mstatus = 0x0000_1800.
  - mie, mtvec, mscratch, mepc, mcause, mtval = 0.
  - Counters = 0.
  - Outputs therefore: mtvec_q = 0, mepc_q = 0, mie_global = 0, csr_read_data = value of the addressed register, illegal_csr = 0 unless csr_write.
- Reset applied mid-operation overrides any pending write or trap in that cycle.
- Reads are combinational and zero-latency. A read of the register being written in the same cycle returns the old value; the new value is visible from the next cycle.
- ECALL: csr_read_data = mtvec in the same cycle (redirect target). mepc/mcause update at that edge.
- ECALL followed by MRET in the next cycle: MRET reads the updated mepc.
- Counter reads return the pre-increment value of the current cycle.

## Structure
- Shared package csr_pkg holds:
  - CSR address constants.
  - Cause code CAUSE_ECALL_M = 11.
  - mstatus bit positions.
  - MISA_VALUE.
  - csr_how encodings (CSR_WRITE, CSR_SET, CSR_CLEAR) and writesource encodings.
- One sub-module, csr_counter64:
  - 64-bit counter with increment enable.
  - Low/high write ports; a write to either half suppresses the increment for that cycle.
  - Instantiated twice, for mcycle and minstret.

## Test plan
- Reset, then read 0x300, 0x301, 0xF14 → 0x0000_1800, 0x4000_0100, 0x0.
- CSRRW 0x305 with rs1_data = 0x0000_0103 → next cycle mtvec_q = 0x0000_0100. Then CSRRS 0x304 with 0x8, then CSRRC 0x304 with 0x8 → mie reads 0x8, then 0x0.
- Set mstatus.MIE = 1, then ECALL with pc = 0x0000_0046 → same cycle csr_read_data = mtvec. Next cycle: mepc_q = 0x44, mcause = 11, mie_global = 0, mstatus bit 7 = 1. Next-cycle MRET → mie_global = 1, mepc_q read = 0x44.
- Write mcycle = 0xFFFF_FFFE, mcycleh = 0 → low reads …FFFE, then …FFFF, then 0x0 with mcycleh = 1. The write cycle shows no increment.
- CSRRW to 0xF14 → illegal_csr = 1, mhartid stays 0. CSRRS 0x340 with rs1_data = 0 → no write, illegal_csr = 0, mcycle keeps incrementing.
- Assert rst_n = 0 in the same cycle as an ECALL → mepc stays 0 and all registers take their reset values.
